// File: rtl/sgd_x_wr_multi.sv
// SGD model write-back controller: gates updated chunks into the model BRAM, issues delayed credits.
// Optional macro SGD_X_WR_WB_INTERVAL_EN adds wb_interval to thin out host write-backs.
module sgd_x_wr_multi #(
    parameter int DATA_WIDTH   = 256,
    parameter int ADDR_WIDTH   = 10,
    parameter int CHUNK_SHIFT  = 7,
    parameter int BANK_SHIFT   = 3,
    parameter int CREDIT_WIDTH = 8,
    parameter int CREDIT_DELAY = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    started,
    input  logic                    abort,
    input  logic [31:0]             mini_batch_size,
    input  logic [31:0]             dimension,
    input  logic [31:0]             number_of_epochs,
    input  logic [31:0]             number_of_samples,
`ifdef SGD_X_WR_WB_INTERVAL_EN
    input  logic [7:0]              wb_interval,
`endif
    input  logic                    x_updated_wr_en,
    input  logic [ADDR_WIDTH-1:0]   x_updated_wr_addr,
    input  logic [DATA_WIDTH-1:0]   x_updated_wr_data,
    output logic                    x_wr_en,
    output logic [ADDR_WIDTH-1:0]   x_wr_addr,
    output logic [DATA_WIDTH-1:0]   x_wr_data,
    output logic [CREDIT_WIDTH-1:0] x_wr_credit_counter,
    output logic                    writing_x_to_host_memory_en,
    input  logic                    writing_x_to_host_memory_done,
    output logic                    sgd_execution_done,
    output logic                    sgd_x_wr_error,
    output logic [3:0]              error_code,
    output logic [31:0]             state_counters_x_wr
);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        START        = 3'd1,
        EPOCH        = 3'd2,
        SAMPLE_CHECK = 3'd3,
        IDLE_S       = 3'd4,
        UPDATE       = 3'd5,
        GLOBAL       = 3'd6,
        FINISH       = 3'd7
    } state_t;

    localparam logic [31:0] SAMPLE_STEP = 32'd1 << BANK_SHIFT;

    state_t                 state_q, state_d;
    logic                   started_r1_q, started_r2_q;
    logic [7:0]             bb_r1_q, bb_r2_q;
    logic [31:0]            dim_r1_q, dim_r2_q;
    logic [9:0]             epochs_r1_q, epochs_r2_q;
    logic [31:0]            samples_r1_q, samples_r2_q;
    logic                   en_s1_q;
    logic [ADDR_WIDTH-1:0]  addr_s1_q;
    logic [DATA_WIDTH-1:0]  data_s1_q;
    logic                   x_wr_en_q;
    logic [ADDR_WIDTH-1:0]  x_wr_addr_q;
    logic [DATA_WIDTH-1:0]  x_wr_data_q;
    logic [31:0]            sample_q, sample_d, chunk_q, chunk_d;
    logic [7:0]             batch_q, batch_d;
    logic [9:0]             epoch_q, epoch_d;
    logic [CREDIT_WIDTH-1:0] credit_q, credit_d;
    logic [CREDIT_DELAY-1:0][CREDIT_WIDTH-1:0] credit_pipe_q;
    logic                   chain_q, chain_d;
    logic                   err_q, err_d, done_q, done_d;
    logic [3:0]             code_q, code_d;
    logic                   update_window, host_req, wb_now;
    logic [32:0]            dim_round;
    logic [31:0]            chunks_per_sample;
    logic [7:0]             bb_m1;
    logic [CREDIT_WIDTH-1:0] bb_credit;
    logic                   unused_cfg;

    assign unused_cfg        = ^{mini_batch_size, number_of_epochs[31:10]};
    assign dim_round         = {1'b0, dim_r2_q} + ((33'd1 << CHUNK_SHIFT) - 33'd1);
    assign chunks_per_sample = 32'(dim_round >> CHUNK_SHIFT);
    assign bb_m1             = bb_r2_q - 8'd1;
    assign bb_credit         = CREDIT_WIDTH'(bb_r2_q);

`ifdef SGD_X_WR_WB_INTERVAL_EN
    logic [7:0] wbi_r1_q, wbi_r2_q;
    logic [9:0] wbi_eff;
    always_ff @(posedge clk) begin
        if (rst) begin
            wbi_r1_q <= '0;
            wbi_r2_q <= '0;
        end else begin
            wbi_r1_q <= wb_interval;
            wbi_r2_q <= wbi_r1_q;
        end
    end
    assign wbi_eff = (wbi_r2_q == 8'd0) ? 10'd1 : {2'b00, wbi_r2_q};
    assign wb_now  = ((epoch_q % wbi_eff) == 10'd0) || (epoch_q == epochs_r2_q);
`else
    assign wb_now = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            started_r1_q  <= 1'b0;
            started_r2_q  <= 1'b0;
            bb_r1_q       <= '0;
            bb_r2_q       <= '0;
            dim_r1_q      <= '0;
            dim_r2_q      <= '0;
            epochs_r1_q   <= '0;
            epochs_r2_q   <= '0;
            samples_r1_q  <= '0;
            samples_r2_q  <= '0;
            en_s1_q       <= 1'b0;
            addr_s1_q     <= '0;
            data_s1_q     <= '0;
            x_wr_en_q     <= 1'b0;
            x_wr_addr_q   <= '0;
            x_wr_data_q   <= '0;
            credit_pipe_q <= '0;
        end else begin
            started_r1_q  <= started;
            started_r2_q  <= started_r1_q;
            bb_r1_q       <= mini_batch_size[BANK_SHIFT+7:BANK_SHIFT];
            bb_r2_q       <= bb_r1_q;
            dim_r1_q      <= dimension;
            dim_r2_q      <= dim_r1_q;
            epochs_r1_q   <= number_of_epochs[9:0];
            epochs_r2_q   <= epochs_r1_q;
            samples_r1_q  <= number_of_samples;
            samples_r2_q  <= samples_r1_q;
            en_s1_q       <= x_updated_wr_en;
            addr_s1_q     <= x_updated_wr_addr;
            data_s1_q     <= x_updated_wr_data;
            x_wr_en_q     <= en_s1_q & update_window;
            x_wr_addr_q   <= addr_s1_q;
            x_wr_data_q   <= data_s1_q;
            credit_pipe_q[0] <= credit_q;
            for (int unsigned i = 1; i < CREDIT_DELAY; i++) begin
                credit_pipe_q[i] <= credit_pipe_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sample_q <= '0;
            chunk_q  <= '0;
            batch_q  <= '0;
            epoch_q  <= '0;
            credit_q <= '0;
            chain_q  <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sample_q <= sample_d;
            chunk_q  <= chunk_d;
            batch_q  <= batch_d;
            epoch_q  <= epoch_d;
            credit_q <= credit_d;
            chain_q  <= chain_d;
            err_q    <= err_d;
            code_q   <= code_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        sample_d      = sample_q;
        chunk_d       = chunk_q;
        batch_d       = batch_q;
        epoch_d       = epoch_q;
        credit_d      = credit_q;
        chain_d       = chain_q;
        err_d         = err_q;
        code_d        = code_q;
        done_d        = done_q;
        update_window = 1'b0;
        host_req      = 1'b0;
        case (state_q)
            IDLE: if (started_r2_q) state_d = START;
            START: begin
                sample_d = '0;
                chunk_d  = '0;
                batch_d  = '0;
                epoch_d  = '0;
                credit_d = '0;
                chain_d  = 1'b0;
                err_d    = 1'b0;
                code_d   = '0;
                done_d   = 1'b0;
                if (dim_r2_q == '0) begin
                    err_d = 1'b1; code_d = 4'd2; state_d = FINISH;
                end else if (bb_r2_q == '0) begin
                    err_d = 1'b1; code_d = 4'd3; state_d = FINISH;
                end else begin
                    state_d = EPOCH;
                end
            end
            EPOCH: begin
                sample_d = '0;
                batch_d  = '0;
                epoch_d  = epoch_q + 10'd1;
                if (epoch_q == epochs_r2_q) begin
                    state_d = FINISH;
                end else begin
                    if (epoch_q == '0) credit_d = credit_q + bb_credit;
                    state_d = SAMPLE_CHECK;
                end
            end
            SAMPLE_CHECK: begin
                sample_d = sample_q + SAMPLE_STEP;
                chunk_d  = '0;
                chain_d  = 1'b0;
                if (en_s1_q) begin
                    err_d = 1'b1; code_d = 4'd1; state_d = FINISH;
                end else if (sample_q == samples_r2_q) begin
                    state_d = GLOBAL;
                end else if (batch_q == bb_m1) begin
                    batch_d = '0; state_d = UPDATE;
                end else begin
                    batch_d = batch_q + 8'd1; state_d = IDLE_S;
                end
            end
            IDLE_S, UPDATE: begin
                update_window = (state_q == UPDATE);
                if (chunk_q == chunks_per_sample) state_d = SAMPLE_CHECK;
                else if (en_s1_q) chunk_d = chunk_q + 32'd1;
                // First chunk of a non-final update slot pre-grants the next bank-batch
                if (update_window && en_s1_q && chunk_q == '0 &&
                    sample_q != samples_r2_q && !chain_q) begin
                    credit_d = credit_q + bb_credit;
                    chain_d  = 1'b1;
                end
            end
            GLOBAL: begin
                host_req = wb_now;
                if (!wb_now || writing_x_to_host_memory_done) begin
                    credit_d = credit_q + bb_credit;
                    state_d  = EPOCH;
                end
            end
            default: ;
        endcase
        // Abort loses to any error raised in the same cycle
        if (abort && state_q != IDLE && state_q != FINISH && !err_d) begin
            err_d    = 1'b1;
            code_d   = 4'd4;
            state_d  = FINISH;
            host_req = 1'b0;
        end
        if (state_d == FINISH) done_d = 1'b1;
    end

    assign x_wr_en                     = x_wr_en_q;
    assign x_wr_addr                   = x_wr_addr_q;
    assign x_wr_data                   = x_wr_data_q;
    assign x_wr_credit_counter         = credit_pipe_q[CREDIT_DELAY-1];
    assign writing_x_to_host_memory_en = host_req;
    assign sgd_execution_done          = done_q;
    assign sgd_x_wr_error              = err_q;
    assign error_code                  = code_q;
    assign state_counters_x_wr         = {x_updated_wr_en, state_q, sample_q[19:0], epoch_q[7:0]};

endmodule

// File: tb/tb_sgd_x_wr_multi.sv
// Scoreboard bench for sgd_x_wr_multi: expected writes, credits and host requests are queued at stimulus time.
module tb_sgd_x_wr_multi;

    logic         clk = 1'b0;
    logic         rst, started, abort;
    logic [31:0]  mini_batch_size, dimension, number_of_epochs, number_of_samples;
`ifdef SGD_X_WR_WB_INTERVAL_EN
    logic [7:0]   wb_interval;
`endif
    logic         x_updated_wr_en;
    logic [9:0]   x_updated_wr_addr;
    logic [255:0] x_updated_wr_data;
    logic         x_wr_en;
    logic [9:0]   x_wr_addr;
    logic [255:0] x_wr_data;
    logic [7:0]   x_wr_credit_counter;
    logic         writing_x_to_host_memory_en, writing_x_to_host_memory_done;
    logic         sgd_execution_done, sgd_x_wr_error;
    logic [3:0]   error_code;
    logic [31:0]  state_counters_x_wr;

    int checks = 0;
    int errors = 0;
    logic [9:0]   wq_addr[$];
    logic [255:0] wq_data[$];
    logic [7:0]   cq[$];
    logic [7:0]   hq[$];
    logic [7:0]   cred_model;
    logic [7:0]   cred_prev;
    logic         host_prev;
    bit           mon_en = 1'b0;
    bit           mon_en_prev = 1'b0;

    always #5 clk = ~clk;

    sgd_x_wr_multi #(
        .DATA_WIDTH(256), .ADDR_WIDTH(10), .CHUNK_SHIFT(7),
        .BANK_SHIFT(3), .CREDIT_WIDTH(8), .CREDIT_DELAY(5)
    ) dut (
        .clk                          (clk),
        .rst                          (rst),
        .started                      (started),
        .abort                        (abort),
        .mini_batch_size              (mini_batch_size),
        .dimension                    (dimension),
        .number_of_epochs             (number_of_epochs),
        .number_of_samples            (number_of_samples),
`ifdef SGD_X_WR_WB_INTERVAL_EN
        .wb_interval                  (wb_interval),
`endif
        .x_updated_wr_en              (x_updated_wr_en),
        .x_updated_wr_addr            (x_updated_wr_addr),
        .x_updated_wr_data            (x_updated_wr_data),
        .x_wr_en                      (x_wr_en),
        .x_wr_addr                    (x_wr_addr),
        .x_wr_data                    (x_wr_data),
        .x_wr_credit_counter          (x_wr_credit_counter),
        .writing_x_to_host_memory_en  (writing_x_to_host_memory_en),
        .writing_x_to_host_memory_done(writing_x_to_host_memory_done),
        .sgd_execution_done           (sgd_execution_done),
        .sgd_x_wr_error               (sgd_x_wr_error),
        .error_code                   (error_code),
        .state_counters_x_wr          (state_counters_x_wr)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] st();
        return state_counters_x_wr[30:28];
    endfunction

    always @(negedge clk) begin
        if (mon_en && !mon_en_prev) begin
            cred_prev = x_wr_credit_counter;
            host_prev = writing_x_to_host_memory_en;
        end else if (mon_en) begin
            if (x_wr_en) begin
                if (wq_addr.size() == 0) begin
                    check("wr_unexpected", x_wr_en, 1'b0);
                end else begin
                    check("wr_addr", x_wr_addr, wq_addr.pop_front());
                    check("wr_data", x_wr_data, wq_data.pop_front());
                end
            end
            if (x_wr_credit_counter != cred_prev) begin
                if (cq.size() == 0) check("credit_extra", x_wr_credit_counter, cred_prev);
                else check("credit_seq", x_wr_credit_counter, cq.pop_front());
                cred_prev = x_wr_credit_counter;
            end
            if (writing_x_to_host_memory_en && !host_prev) begin
                if (hq.size() == 0) check("host_unexpected", writing_x_to_host_memory_en, 1'b0);
                else check("host_epoch", state_counters_x_wr[7:0], hq.pop_front());
            end
            host_prev = writing_x_to_host_memory_en;
        end
        mon_en_prev = mon_en;
    end

    task automatic do_reset();
        mon_en = 1'b0;
        started = 1'b0; abort = 1'b0;
        x_updated_wr_en = 1'b0; writing_x_to_host_memory_done = 1'b0;
        wq_addr.delete(); wq_data.delete(); cq.delete(); hq.delete();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_wr_en", x_wr_en, 1'b0);
        check("rst_credit", x_wr_credit_counter, 8'd0);
        check("rst_host_en", writing_x_to_host_memory_en, 1'b0);
        check("rst_done", sgd_execution_done, 1'b0);
        check("rst_error", sgd_x_wr_error, 1'b0);
        check("rst_code", error_code, 4'd0);
        check("rst_counters", state_counters_x_wr, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;
    endtask

    task automatic set_cfg(input int mbs, input int dim, input int epochs, input int samples, input int wbi);
        mini_batch_size   = 32'(mbs);
        dimension         = 32'(dim);
        number_of_epochs  = 32'(epochs);
        number_of_samples = 32'(samples);
`ifdef SGD_X_WR_WB_INTERVAL_EN
        wb_interval = 8'(wbi);
`endif
    endtask

    task automatic drive_chunks(input int n, input bit expect_wr);
        logic [9:0]   a;
        logic [255:0] d;
        for (int c = 0; c < n; c++) begin
            a = 10'($urandom_range(0, 1023));
            d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            x_updated_wr_en = 1'b1; x_updated_wr_addr = a; x_updated_wr_data = d;
            if (expect_wr) begin wq_addr.push_back(a); wq_data.push_back(d); end
            @(negedge clk);
        end
        x_updated_wr_en = 1'b0;
    endtask

    task automatic wait_slot(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (st() == 3'd4 || st() == 3'd5) begin ok = 1'b1; return; end
        end
        check("slot_timeout", st(), 3'd4);
    endtask

    task automatic wait_leave(input logic [2:0] cur, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (st() != cur) begin ok = 1'b1; return; end
        end
        check("leave_timeout", st(), 3'd3);
    endtask

    task automatic wait_host(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (writing_x_to_host_memory_en) begin ok = 1'b1; return; end
        end
        check("host_timeout", writing_x_to_host_memory_en, 1'b1);
    endtask

    task automatic finish_checks(input logic exp_err, input logic [3:0] exp_code, input int extra);
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (sgd_execution_done) seen = 1'b1;
            else @(negedge clk);
        end
        check("done", sgd_execution_done, 1'b1);
        check("finish_state", st(), 3'd7);
        check("error_flag", sgd_x_wr_error, exp_err);
        check("error_code", error_code, exp_code);
        drive_chunks(extra, 1'b0);
        repeat (8) @(negedge clk);
        check("credit_final", x_wr_credit_counter, cred_model);
        check("wr_left", 32'(wq_addr.size()), 32'd0);
        check("credit_left", 32'(cq.size()), 32'd0);
        check("host_left", 32'(hq.size()), 32'd0);
    endtask

    task automatic run_batch(input int mbs, input int dim, input int epochs, input int samples,
                             input int wbi, input int resp_delay, input bit lat_chk);
        int bb, cps, slots;
        bit ok, upd, wbe;
        logic [2:0] cur;
        logic [7:0] old_c;
        bb = (mbs >> 3) & 255; cps = (dim + 127) / 128; slots = samples / 8;
        set_cfg(mbs, dim, epochs, samples, wbi);
        do_reset();
        cred_model = 8'(bb); cq.push_back(cred_model);
        started = 1'b1;
        for (int e = 1; e <= epochs; e++) begin
            for (int s = 0; s < slots; s++) begin
                upd = (s % bb) == (bb - 1);
                wait_slot(ok);
                if (!ok) return;
                cur = st();
                check("slot_state", cur, upd ? 3'd5 : 3'd4);
                if (upd && (s + 1) * 8 != samples) begin
                    cred_model = cred_model + 8'(bb); cq.push_back(cred_model);
                end
                drive_chunks(cps, upd);
                wait_leave(cur, ok);
                if (!ok) return;
            end
            wbe = 1'b1;
`ifdef SGD_X_WR_WB_INTERVAL_EN
            wbe = (e % ((wbi == 0) ? 1 : wbi) == 0) || (e == epochs);
`endif
            if (wbe) begin
                hq.push_back(8'(e));
                wait_host(ok);
                if (!ok) return;
                repeat (resp_delay) @(negedge clk);
                old_c = cred_model;
                cred_model = cred_model + 8'(bb); cq.push_back(cred_model);
                writing_x_to_host_memory_done = 1'b1;
                @(negedge clk);
                writing_x_to_host_memory_done = 1'b0;
                if (lat_chk) begin
                    repeat (4) @(negedge clk);
                    check("credit_hold", x_wr_credit_counter, old_c);
                    @(negedge clk);
                    check("credit_delay", x_wr_credit_counter, cred_model);
                end
            end else begin
                cred_model = cred_model + 8'(bb); cq.push_back(cred_model);
            end
        end
        finish_checks(1'b0, 4'd0, 0);
    endtask

    task automatic cfg_error_run(input int mbs, input int dim, input logic [3:0] code);
        int n = 0;
        set_cfg(mbs, dim, 1, 32, 1);
        do_reset();
        cred_model = 8'd0;
        started = 1'b1;
        while (n < 20 && !sgd_execution_done) begin
            @(negedge clk);
            n++;
        end
        check("cfg_err_cycles", 32'(n), 32'd4);
        finish_checks(1'b1, code, 0);
    endtask

    initial begin
        bit ok;
        rst = 1'b1; started = 1'b0; abort = 1'b0;
        x_updated_wr_en = 1'b0; x_updated_wr_addr = '0; x_updated_wr_data = '0;
        writing_x_to_host_memory_done = 1'b0;
        set_cfg(16, 256, 1, 32, 1);

        // Nominal mini-batch with 3-cycle host handshake and exact credit latency
        run_batch(16, 256, 1, 32, 1, 3, 1'b1);

        // Chunk arriving while the FSM checks the next sample slot
        set_cfg(16, 256, 1, 32, 1);
        do_reset();
        cred_model = 8'd2; cq.push_back(cred_model);
        started = 1'b1;
        wait_slot(ok);
        if (ok) begin
            check("t2_slot_state", st(), 3'd4);
            drive_chunks(5, 1'b0);
            finish_checks(1'b1, 4'd1, 3);
        end

        // Config errors: dimension 0 beats bank_batch 0, then bank_batch 0 alone
        cfg_error_run(4, 0, 4'd2);
        cfg_error_run(4, 256, 4'd3);

        // Abort in UPDATE one cycle after a chunk reached the write stage
        set_cfg(16, 256, 1, 32, 1);
        do_reset();
        cred_model = 8'd2; cq.push_back(cred_model);
        started = 1'b1;
        wait_slot(ok);
        if (ok) begin
            drive_chunks(2, 1'b0);
            wait_leave(3'd4, ok);
            wait_slot(ok);
        end
        if (ok) begin
            check("t4_slot_state", st(), 3'd5);
            cred_model = 8'd4; cq.push_back(cred_model);
            drive_chunks(1, 1'b1);
            @(negedge clk);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            finish_checks(1'b1, 4'd4, 0);
        end

        // Credit wrap: 200 epochs of one sample slot each
        run_batch(16, 128, 200, 8, 1, 1, 1'b0);

`ifdef SGD_X_WR_WB_INTERVAL_EN
        run_batch(16, 128, 7, 8, 3, 2, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got %0d checks expected completion", checks);
        $fatal(1, "timeout");
    end

endmodule
